ifid_elastic_stage: RTL and testbench
=====================================

Name: ifid_elastic_stage

Overview:
- Parametrised successor to the fixed IF/ID pipeline register.
- Replaces the single stall/flush register with a DEPTH-entry elastic buffer carrying {instruction, pc+4}.
- Uses a valid/ready handshake on both sides and a flush that presents a NOP bubble.
- Adds a saturating back-pressure counter. Sits between fetch and decode.

Parameters:
- INSTR_W, 32, instruction width in bits
- PC_W, 32, pc+4 width in bits
- DEPTH, 2, buffer entries; power of two, at least 1
- NOP_INSTR, 32'h7E00_0000, bubble encoding shown to decode when empty or flushed
- STALL_CNT_W, 16, width of the back-pressure counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- in_valid  in  1  fetch presents a beat
- in_ready  out  1  stage accepts the beat this cycle
- in_instr  in  INSTR_W  fetched instruction
- in_pcplus4  in  PC_W  fetched pc+4
- out_valid  out  1  head entry valid toward decode
- out_ready  in  1  decode consumes the head this cycle
- out_instr  out  INSTR_W  head instruction, or NOP_INSTR when empty
- out_pcplus4  out  PC_W  head pc+4, or 0 when empty
- flush  in  1  discard all entries (branch/jump redirect)
- occupancy  out  $clog2(DEPTH)+1  entries held
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (reset=0 at posedge):
  - Pointers and occupancy go to 0; stall_cnt goes to 0.
  - Outputs then read out_valid=0, out_instr=NOP_INSTR, out_pcplus4=0, in_ready=1.
  - Reset mid-operation discards all contents in the same edge.
- Storage:
  - Circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits; each pointer wraps modulo DEPTH.
  - Occupancy is tracked separately to distinguish full from empty.
  - For DEPTH=1, pointers are constant 0.
- Derived signals:
  - full = (occupancy==DEPTH); empty = (occupancy==0).
  - in_ready = !full || out_ready. This is the only combinational input-to-output path.
  - out_valid = !empty.
  - out_instr/out_pcplus4 come from the head entry, forced to NOP_INSTR/0 when empty. No other combinational logic.
- Handshakes:
  - push = in_valid && in_ready && !flush; pop = out_valid && out_ready && !flush.
- Latency and throughput:
  - One cycle: a beat pushed at edge N is visible at out_* after edge N. There is no same-cycle bypass when empty.
  - Throughput is one beat per cycle at any DEPTH, including DEPTH=1.
- Simultaneous events:
  - push and pop together: occupancy unchanged, both pointers advance. This applies when full too, because in_ready=1 via out_ready.
  - push only: occupancy+1. pop only: occupancy-1.
- Flush:
  - Dominates push and pop: occupancy, rd_ptr and wr_ptr go to 0. Any input beat in the same cycle is dropped.
  - Next cycle: out_valid=0, out_instr=NOP_INSTR.
  - in_ready is still driven per the normal rule during flush; fetch must not treat its beat as accepted when it also asserts flush.
  - Flush has no effect on stall_cnt.
- Storage writes:
  - Data is written only on push; entries are never cleared.
  - Stale contents are never visible, because of the empty mux.
- stall_cnt:
  - Increments when out_valid && !out_ready && !flush, and saturates at all-ones.
  - Cleared only by reset.
- Illegal but tolerated input:
  - in_valid with X data while in_ready=0 must not corrupt state.
  - Deasserting in_valid before acceptance is allowed; fetch redirects.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP_INSTR default constant.
  - Packed typedef ifid_entry_t {instr, pcplus4}.
  - Helper function for the occupancy width.
- One sub-module, sat_counter (parameter W, inputs inc and reset), implements stall_cnt. The buffer itself stays inline.

Test Plan:
- Reset, then idle, DEPTH=2: out_valid=0, out_instr=32'h7E00_0000, out_pcplus4=0, occupancy=0, in_ready=1, stall_cnt=0.
- Streaming with out_ready=1:
  - Stimulus: push instr 0x11,0x22,0x33 with pc 4,8,12 on consecutive cycles.
  - Response: same values on out_* one cycle later, back-to-back; occupancy stays 1.
- Back-pressure:
  - Stimulus: out_ready=0, push 3 beats.
  - Response: occupancy=2, in_ready=0 after the 2nd; the 3rd beat is held by fetch. stall_cnt increments each stalled cycle.
  - Stimulus: raise out_ready.
  - Response: order preserved 0x11, 0x22, then 0x33.
- Full with simultaneous push+pop, DEPTH=2: occupancy stays 2 and pointers wrap. Output order matches input order across at least 5 beats.
- Flush:
  - Stimulus: flush with 2 entries and an in_valid beat in the same cycle.
  - Response: next cycle occupancy=0, out_valid=0, out_instr=0x7E00_0000; the dropped beat never appears.
- stall_cnt saturation (STALL_CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles; stall_cnt reaches 15 and holds. reset=0 mid-stall clears everything the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants, entry type and sizing helper for the fetch/decode pipeline.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h7E00_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } ifid_entry_t;

    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; cleared only by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/ifid_elastic_stage.sv
// ifid_elastic_stage: DEPTH-entry valid/ready buffer between fetch and decode,
// with flush-to-bubble and a saturating back-pressure counter.
module ifid_elastic_stage
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W     = 32,
    parameter int                 PC_W        = 32,
    parameter int                 DEPTH       = 2,
    parameter logic [INSTR_W-1:0] NOP_INSTR   = INSTR_W'(NOP_INSTR_DEFAULT),
    parameter int                 STALL_CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTR_W-1:0]           in_instr,
    input  logic [PC_W-1:0]              in_pcplus4,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTR_W-1:0]           out_instr,
    output logic [PC_W-1:0]              out_pcplus4,
    input  logic                         flush,
    output logic [occ_width(DEPTH)-1:0]  occupancy,
    output logic [STALL_CNT_W-1:0]       stall_cnt
);

    localparam int OCC_W = occ_width(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic               full, empty, push, pop;

    assign full        = occupancy == OCC_W'(DEPTH);
    assign empty       = occupancy == '0;
    assign in_ready    = !full || out_ready;
    assign out_valid   = !empty;
    assign push        = in_valid && in_ready && !flush;
    assign pop         = out_valid && out_ready && !flush;
    assign out_instr   = empty ? NOP_INSTR : instr_mem[rd_ptr];
    assign out_pcplus4 = empty ? '0 : pc_mem[rd_ptr];
    // explicit wrap keeps DEPTH=1 pointers pinned at zero
    assign rd_nxt      = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    assign wr_nxt      = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_nxt;
            if (pop)
                rd_ptr <= rd_nxt;
            if (push != pop)
                occupancy <= push ? occupancy + 1'b1 : occupancy - 1'b1;
        end
    end

    // storage is never cleared; the empty mux hides stale entries
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pcplus4;
        end
    end

    sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid && !out_ready && !flush),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_ifid_elastic_stage.sv
// tb_ifid_elastic_stage: directed scoreboard bench for ifid_elastic_stage (DEPTH=2, 4-bit stall counter).
module tb_ifid_elastic_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pcplus4 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pcplus4;
    logic        flush = 1'b0;
    logic [1:0]  occupancy;
    logic [3:0]  stall_cnt;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] q[$];
    int          scnt = 0;

    always #5 clk = ~clk;

    ifid_elastic_stage #(
        .INSTR_W     (32),
        .PC_W        (32),
        .DEPTH       (2),
        .NOP_INSTR   (32'h7E00_0000),
        .STALL_CNT_W (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pcplus4  (in_pcplus4),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pcplus4 (out_pcplus4),
        .flush       (flush),
        .occupancy   (occupancy),
        .stall_cnt   (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("out_instr", out_instr, q.size() != 0 ? q[0][63:32] : 32'h7E00_0000);
        chk("out_pcplus4", out_pcplus4, q.size() != 0 ? q[0][31:0] : 32'h0);
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("stall_cnt", 32'(stall_cnt), 32'(scnt));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        q.delete();
        scnt = 0;
        #1;
        chk_out();
        chk("in_ready_rst", 32'(in_ready), 32'h1);
        reset = 1'b1;
    endtask

    // one clock: drive, check in_ready, advance the model at the edge, check outputs
    task automatic cyc(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic rdy, input logic fl);
        bit rdy_m, push, pop, stall;
        in_valid = v;
        in_instr = i;
        in_pcplus4 = p;
        out_ready = rdy;
        flush = fl;
        #1;
        rdy_m = (q.size() < 2) || rdy;
        chk("in_ready", 32'(in_ready), 32'(rdy_m));
        push  = v && rdy_m && !fl;
        pop   = (q.size() != 0) && rdy && !fl;
        stall = (q.size() != 0) && !rdy && !fl;
        @(posedge clk);
        if (fl) q.delete();
        if (pop) void'(q.pop_front());
        if (push) q.push_back({i, p});
        if (stall && scnt < 15) scnt++;
        #1;
        chk_out();
    endtask

    initial begin
        do_reset();
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // streaming
        cyc(1'b1, 32'h11, 32'd4, 1'b1, 1'b0);
        cyc(1'b1, 32'h22, 32'd8, 1'b1, 1'b0);
        cyc(1'b1, 32'h33, 32'd12, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // back-pressure: third beat held by fetch, then X data while not ready
        cyc(1'b1, 32'h11, 32'd4, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 32'd8, 1'b0, 1'b0);
        cyc(1'b1, 32'h33, 32'd12, 1'b0, 1'b0);
        cyc(1'b1, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 1'b0, 1'b0);
        cyc(1'b1, 32'h33, 32'd12, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // full with simultaneous push and pop, pointers wrap
        cyc(1'b1, 32'h40, 32'h100, 1'b0, 1'b0);
        cyc(1'b1, 32'h41, 32'h104, 1'b0, 1'b0);
        for (int k = 2; k < 8; k++) cyc(1'b1, 32'h40 + k, 32'h100 + 4 * k, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // flush with two entries and a beat in the same cycle
        cyc(1'b1, 32'h51, 32'h200, 1'b0, 1'b0);
        cyc(1'b1, 32'h52, 32'h204, 1'b0, 1'b0);
        cyc(1'b1, 32'h99, 32'h208, 1'b1, 1'b1);
        chk("flush_occ", 32'(occupancy), 32'h0);
        chk("flush_nop", out_instr, 32'h7E00_0000);
        for (int k = 0; k < 2; k++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h61, 32'h300, 1'b0, 1'b0);

        // stall counter saturation, then reset mid-stall
        for (int k = 0; k < 20; k++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("stall_sat", 32'(stall_cnt), 32'd15);
        do_reset();
        chk("rst_stall", 32'(stall_cnt), 32'h0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
